// File: rtl/weight_buffer_ctrl_pkg.sv
// Shared widths and state encoding for the weight buffer controller.
// ARRAYWIDTH/DATASIZE default here only if the surrounding build has not defined them.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 8
`endif

package weight_buffer_ctrl_pkg;
  localparam int ARRAY_WIDTH = `ARRAYWIDTH;
  localparam int DATA_SIZE   = `DATASIZE;
  localparam int ROW_W       = ARRAY_WIDTH * DATA_SIZE;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_FULL  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
endpackage

// File: rtl/weight_buffer_ctrl_if.sv
// Upstream weight-row handshake into the weight buffer controller.
// A row transfers on any posedge where in_valid && in_ready; in_ready never looks at in_valid,
// and the source must hold in_row steady while in_valid is high and in_ready is low.
interface weight_buffer_ctrl_if;
  import weight_buffer_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;

  modport master (output in_valid, output in_row, input in_ready);
  modport slave  (input in_valid, input in_row, output in_ready);
endinterface

// File: rtl/weight_buffer_ctrl.sv
// Load/drain sequencer for the systolic-array weight shift registers: fills DEPTH rows,
// then on start streams them out for DEPTH cycles and pulses done.
module weight_buffer_ctrl
  import weight_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH = ARRAY_WIDTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  weight_buffer_ctrl_if.slave up,
  input  logic              start,
  input  logic              abort,
  output logic              wb_load_en,
  output logic              wb_out_en,
  output logic [ROW_W-1:0]  wb_in_weight,
  output logic              weight_valid,
  output logic              full,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state,
  output logic [CNT_W-1:0]  dbg_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_c;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accept = up.in_valid && in_ready_c;

  // abort outranks accept and start; it is a no-op in IDLE and DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = ONE;
          state_d = (DEPTH == 1) ? ST_FULL : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (start) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready_c   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    wb_load_en   = accept;
    wb_out_en    = (state_q == ST_DRAIN);
    weight_valid = (state_q == ST_DRAIN);
    full         = (state_q == ST_FULL);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
  end

  assign up.in_ready   = in_ready_c;
  assign wb_in_weight  = up.in_row;
  assign dbg_state     = state_q;
  assign dbg_cnt       = cnt_q;

  // the buffer cannot shift in and out on the same edge
  a_no_load_and_out: assert property (@(posedge clk) disable iff (rst) !(wb_load_en && wb_out_en));
endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Bench for weight_buffer_ctrl: directed tile scenarios plus random traffic, all checked
// every cycle against a row-count/queue model and a bench-side weight shift register.
module tb_weight_buffer_ctrl;
  import weight_buffer_ctrl_pkg::*;

  localparam int DEPTH = ARRAY_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic wb_load_en, wb_out_en, weight_valid, full, busy, done;
  logic [ROW_W-1:0] wb_in_weight;
  state_t dbg_state;
  logic [CNT_W-1:0] dbg_cnt;

  weight_buffer_ctrl_if up_if ();

  weight_buffer_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .up           (up_if),
    .start        (start),
    .abort        (abort),
    .wb_load_en   (wb_load_en),
    .wb_out_en    (wb_out_en),
    .wb_in_weight (wb_in_weight),
    .weight_valid (weight_valid),
    .full         (full),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state),
    .dbg_cnt      (dbg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tile progress as plain counts: rows gathered, drain cycles left, done owed.
  int  m_loaded = 0;
  int  m_drain_rem = 0;
  bit  m_done = 0;
  bit  m_accepted = 0;
  logic [ROW_W-1:0] m_tile[$];
  logic [ROW_W-1:0] m_drain_tile[$];
  logic [ROW_W-1:0] exp_q[$];        // every row the array side should have seen, in order
  logic [ROW_W-1:0] wb_sr[DEPTH];    // stand-in for weight_buffer, driven by the DUT outputs
  logic [ROW_W-1:0] drained_q[$];
  int n_load = 0, n_out = 0, n_done = 0;

  logic   e_ready, e_load, e_out, e_full, e_busy;
  state_t e_state;
  logic [ROW_W-1:0] obs;

  initial for (int i = 0; i < DEPTH; i++) wb_sr[i] = '0;

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      e_ready = !m_done && (m_drain_rem == 0) && (m_loaded < DEPTH);
      e_load  = e_ready && up_if.in_valid;
      e_out   = (m_drain_rem > 0);
      e_full  = !m_done && !e_out && (m_loaded == DEPTH);
      e_busy  = m_done || e_out || (m_loaded > 0);
      if (m_done)                e_state = ST_DONE;
      else if (e_out)            e_state = ST_DRAIN;
      else if (m_loaded == DEPTH) e_state = ST_FULL;
      else if (m_loaded > 0)     e_state = ST_LOAD;
      else                       e_state = ST_IDLE;

      chk("in_ready", up_if.in_ready, e_ready);
      chk("wb_load_en", wb_load_en, e_load);
      chk("wb_in_weight", wb_in_weight, up_if.in_row);
      chk("wb_out_en", wb_out_en, e_out);
      chk("weight_valid", weight_valid, e_out);
      chk("full", full, e_full);
      chk("busy", busy, e_busy);
      chk("done", done, m_done);
      chk("dbg_state", dbg_state, e_state);
      if (!m_done) chk("dbg_cnt", dbg_cnt, e_out ? (DEPTH - m_drain_rem) : m_loaded);

      if (wb_load_en) begin
        for (int i = DEPTH - 1; i > 0; i--) wb_sr[i] = wb_sr[i-1];
        wb_sr[0] = wb_in_weight;
        n_load++;
      end else if (wb_out_en) begin
        obs = wb_sr[DEPTH-1];
        for (int i = DEPTH - 1; i > 0; i--) wb_sr[i] = wb_sr[i-1];
        wb_sr[0] = '0;
        drained_q.push_back(obs);
        n_out++;
        if (e_out) begin
          exp_q.push_back(m_drain_tile[DEPTH - m_drain_rem]);
          chk("drain_data", obs, exp_q[exp_q.size()-1]);
        end
      end
      if (done) n_done++;
      m_accepted = e_load;

      // advance the model by the inputs seen at the coming posedge
      if (rst) begin
        m_loaded = 0; m_drain_rem = 0; m_done = 0; m_tile.delete();
      end else if (m_done) begin
        m_done = 0;
      end else if (m_drain_rem > 0) begin
        if (abort) m_drain_rem = 0;
        else begin
          m_drain_rem--;
          if (m_drain_rem == 0) m_done = 1;
        end
      end else if (m_loaded == DEPTH) begin
        if (abort) begin
          m_loaded = 0; m_tile.delete();
        end else if (start) begin
          m_drain_tile = m_tile; m_tile.delete(); m_loaded = 0; m_drain_rem = DEPTH;
        end
      end else if (abort && m_loaded > 0) begin
        m_loaded = 0; m_tile.delete();
      end else if (up_if.in_valid) begin
        m_loaded++; m_tile.push_back(up_if.in_row);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [ROW_W-1:0] tiles[4][4];

  task automatic step(input logic v, input logic [ROW_W-1:0] row,
                      input logic st = 1'b0, input logic ab = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    up_if.in_valid = v;
    up_if.in_row   = row;
    start          = st;
    abort          = ab;
    rst            = r;
  endtask

  task automatic fill(input int k);
    for (int i = 0; i < DEPTH; i++) step(1'b1, tiles[k][i]);
  endtask

  task automatic drain_and_check(input int k, input string tag);
    int b_out, b_done, b_drn;
    b_out = n_out; b_done = n_done; b_drn = drained_q.size();
    step(1'b0, '0, 1'b1);
    repeat (DEPTH) step(1'b0, '0);
    #3;
    chk({tag, "_out_cycles"}, n_out - b_out, 4);
    step(1'b0, '0);
    #3;
    chk({tag, "_done_pulse"}, done, 1'b1);
    step(1'b0, '0);
    #3;
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_ready_after"}, up_if.in_ready, 1'b1);
    chk({tag, "_done_count"}, n_done - b_done, 1);
    chk({tag, "_drain_count"}, drained_q.size() - b_drn, 4);
    if (drained_q.size() - b_drn == 4)
      for (int i = 0; i < 4; i++) chk({tag, "_row_order"}, drained_q[b_drn+i], tiles[k][i]);
  endtask

  // ---------------- stimulus ----------------
  int b_load, b_out, b_done;
  logic cur_v;
  logic [ROW_W-1:0] cur_row;

  initial begin
    tiles[0] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    tiles[1] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    tiles[2] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    tiles[3] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678};

    up_if.in_valid = 1'b0; up_if.in_row = '0; start = 1'b0; abort = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    step(1'b0, '0);
    #3;
    chk("reset_ready", up_if.in_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_full", full, 1'b0);
    chk("reset_cnt", dbg_cnt, 0);
    chk("reset_state", dbg_state, ST_IDLE);

    // continuous fill, then drain
    b_load = n_load;
    fill(0);
    step(1'b0, '0);
    #3;
    chk("fill_loads", n_load - b_load, 4);
    chk("fill_full", full, 1'b1);
    chk("fill_ready_low", up_if.in_ready, 1'b0);
    drain_and_check(0, "drain_a");

    // bubbled fill
    b_load = n_load;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, tiles[1][i]);
      step(1'b0, tiles[1][i]);
    end
    #3;
    chk("bubble_loads", n_load - b_load, 4);
    chk("bubble_full", full, 1'b1);
    drain_and_check(1, "drain_b");

    // start outside FULL is ignored
    b_load = n_load; b_out = n_out;
    step(1'b0, '0, 1'b1);
    step(1'b1, tiles[2][0]);
    step(1'b1, tiles[2][1]);
    step(1'b0, '0, 1'b1);
    step(1'b1, tiles[2][2]);
    step(1'b1, tiles[2][3]);
    step(1'b0, '0);
    #3;
    chk("ign_start_out", n_out - b_out, 0);
    chk("ign_start_loads", n_load - b_load, 4);
    chk("ign_start_full", full, 1'b1);
    drain_and_check(2, "drain_c");

    // abort during the second drain cycle
    fill(0);
    b_out = n_out; b_done = n_done;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0);
    #3;
    chk("abort_out_cycles", n_out - b_out, 2);
    chk("abort_no_done", n_done - b_done, 0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_state", dbg_state, ST_IDLE);
    fill(3);
    drain_and_check(3, "drain_after_abort");

    // reset after three rows
    for (int i = 0; i < 3; i++) step(1'b1, tiles[0][i]);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0);
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ready", up_if.in_ready, 1'b1);
    chk("rst_load_en", wb_load_en, 1'b0);
    chk("rst_out_en", wb_out_en, 1'b0);
    chk("rst_cnt", dbg_cnt, 0);
    for (int i = 0; i < 3; i++) step(1'b1, tiles[1][i]);
    step(1'b0, '0);
    #3;
    chk("rst_refill_not_full", full, 1'b0);
    step(1'b1, tiles[1][3]);
    step(1'b0, '0);
    #3;
    chk("rst_refill_full", full, 1'b1);
    drain_and_check(1, "drain_after_rst");

    // random traffic; a row is held until it is taken
    cur_v = 1'b0; cur_row = '0;
    for (int n = 0; n < 600; n++) begin
      if (!cur_v || m_accepted) begin
        cur_v   = ($urandom_range(0, 9) < 7);
        cur_row = $urandom;
      end
      step(cur_v, cur_row,
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 99) == 0));
    end
    repeat (DEPTH + 4) step(1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/weight_buffer_ctrl.md
Name: weight_buffer_ctrl

Overview:
- Sequences the per-column weight shift registers that feed the systolic array.
- Accepts weight rows from upstream over a valid/ready handshake and fills the buffer with exactly DEPTH rows.
- On a start request, drains the buffer into the array for DEPTH consecutive cycles and signals completion.
- Sits between the weight-fetch logic and weight_buffer. It drives weight_buffer's load_en, out_en and in_weight.

Parameters:
- DEPTH, default `ARRAYWIDTH: number of rows held per column shift register; rows per load/drain tile.
- CNT_W, default $clog2(DEPTH+1): row counter width.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream row valid.
- in_ready  output  1  controller accepts a row this cycle.
- in_row  input  `ARRAYWIDTH*`DATASIZE  upstream weight row, one `DATASIZE lane per column.
- start  input  1  single-cycle request to drain a full buffer into the array.
- abort  input  1  discard buffer contents and return to IDLE.
- wb_load_en  output  1  to weight_buffer load_en.
- wb_out_en  output  1  to weight_buffer out_en.
- wb_in_weight  output  `ARRAYWIDTH*`DATASIZE  to weight_buffer in_weight.
- weight_valid  output  1  array-side qualifier, asserted in every cycle wb_out_en is high.
- full  output  1  buffer holds DEPTH rows and awaits start.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse after the last drain cycle.

Behaviour:
- States: IDLE, LOAD, FULL, DRAIN, DONE. Only the state register and row counter cnt are registered.
- Reset (synchronous, rst=1 at posedge):
  - state returns to IDLE and cnt to 0.
  - All outputs read 0 in the following cycle, except in_ready, which is 1 because the state is IDLE.
  - Reset in any state, including mid-LOAD or mid-DRAIN, abandons the operation. No done pulse is issued.
- in_ready = (state==IDLE || state==LOAD). This is combinational from state only and never depends on in_valid.
- Accept = in_valid && in_ready.
  - wb_load_en = accept, combinational.
  - wb_in_weight = in_row, passed straight through, zero latency.
  - The row is shifted into weight_buffer at the same posedge.
- IDLE:
  - On accept: cnt<=1. Go to FULL if DEPTH==1, else LOAD.
- LOAD:
  - Each accept does cnt<=cnt+1.
  - On the accept that makes cnt==DEPTH, go to FULL. in_ready drops in the next cycle.
  - Cycles with in_valid=0 are bubbles: no shift, cnt holds.
- FULL:
  - full=1.
  - On start: cnt<=0 and go to DRAIN.
  - start in any other state is ignored, with no latching.
- DRAIN:
  - wb_out_en=1 and weight_valid=1 for exactly DEPTH consecutive cycles. These are registered-state outputs, so there is no bubble.
  - cnt increments each cycle. After the cycle with cnt==DEPTH-1, go to DONE.
- DONE:
  - done=1 for one cycle, then go to IDLE with cnt<=0.
  - in_ready=0 in DONE, so there are no back-to-back tiles without one idle cycle.
- abort:
  - Valid in LOAD, FULL or DRAIN. Next state is IDLE, cnt<=0, no done pulse.
  - abort has priority over accept and start in the same cycle. wb_load_en is still gated by in_ready, so a row offered in the same cycle is shifted but discarded.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in FULL: abort wins.
- Upstream must hold in_row stable while in_valid=1 && in_ready=0. The controller does not check this.
- Counter never exceeds DEPTH. No wrap-around occurs because it is cleared on every state exit to IDLE or DRAIN.
- Assertions for verification:
  - wb_load_en and wb_out_en are never high together.
  - Exactly DEPTH accepts between leaving IDLE and reaching FULL.

Decomposition:
- Shared package/header: `ARRAYWIDTH and `DATASIZE (existing), plus the state encoding localparams ST_IDLE..ST_DONE (3 bits) so the top-level debug status can decode them.
- No sub-module: one FSM plus counter. weight_buffer is instantiated beside it at the top level, not inside it.

Test Plan:
- Fill, ARRAYWIDTH=4, DATASIZE=8: rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, in_valid=1 continuously → wb_load_en high for 4 cycles, full=1 in cycle 5, in_ready=0.
- Bubbled fill: same rows with in_valid toggling 1,0,1,0… → exactly 4 load pulses, cnt holds during gaps, full after the 4th accept.
- Drain: start in FULL → wb_out_en and weight_valid high for exactly 4 cycles, done pulse in cycle 5, busy=0 and in_ready=1 in cycle 6. Array-side data order is checked against the filled rows.
- Ignored start: start asserted in IDLE and again after 2 rows loaded → no wb_out_en, fill continues normally.
- Abort mid-DRAIN after 2 out_en cycles → IDLE next cycle, no done, next 4-row fill and drain complete correctly.
- Reset mid-LOAD after 3 rows, with rst held for 1 cycle → busy=0, full=0, in_ready=1, all enables 0 and cnt=0. A subsequent fill requires 4 fresh rows.
